// File: rtl/uart_transmit_if.sv
// Byte handshake and serial line bundle for the UART transmitter.
// The slave modport is the transmitter. The master modport is whatever feeds it bytes and watches the line.
interface uart_transmit_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 serial_data_out;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  serial_data_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output serial_data_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_transmit.sv
// UART transmitter: a one-entry holding buffer feeds a start/data/parity/stop framer.
// Every bit lasts OVERSAMPLE clocks of the shared 16x receive clock.
// All outputs are registered. tx_ready is the only exception, and it is just the inverse of one flop.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for the holding buffer to fill
// S_START  | start bit (line low) for OVERSAMPLE cycles
// S_DATA   | DATA_BITS data bits, LSB first, OVERSAMPLE cycles each
// S_PARITY | optional even/odd parity bit for OVERSAMPLE cycles
// S_STOP   | STOP_BITS*OVERSAMPLE cycles of line high, then reload or idle
module uart_transmit #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              tx_sample_clk,
    input  logic              reset_n,
    uart_transmit_if.slave    bus
);

    localparam int SW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int STOP_TOTAL = STOP_BITS * OVERSAMPLE;
    localparam int STW        = (STOP_TOTAL > 1) ? $clog2(STOP_TOTAL) : 1;
    localparam int BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0]  SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [STW-1:0] STOP_LAST   = STW'(STOP_TOTAL - 1);
    localparam logic [BW-1:0]  BIT_LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [SW-1:0]        r_sample_cnt;
    logic [STW-1:0]       r_stop_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity_bit;
    logic                 r_line;
    logic                 r_busy;
    logic                 r_done;

    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;

    logic w_accept;
    logic w_sample_last;
    logic w_stop_last;
    logic w_load;
    logic w_parity_bit;

    // Accept is gated by the buffer being empty, so it can never coincide with a load.
    assign w_accept      = bus.tx_valid && !r_buf_full;
    assign w_sample_last = (r_sample_cnt == SAMPLE_LAST);
    assign w_stop_last   = (r_stop_cnt == STOP_LAST);
    // Load from idle, or straight from the final stop cycle so that back-to-back frames have no gap.
    assign w_load        = r_buf_full && ((r_state == S_IDLE) ||
                                          ((r_state == S_STOP) && w_stop_last));
    // Even parity is the XOR of the data bits. Odd parity is its inverse.
    assign w_parity_bit  = (^r_buf) ^ (PARITY == 2);

    assign bus.tx_ready        = !r_buf_full;
    assign bus.serial_data_out = r_line;
    assign bus.tx_busy         = r_busy;
    assign bus.tx_done         = r_done;

    // Holding buffer: fill on accept, empty when the framer takes the byte.
    always_ff @(posedge tx_sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= bus.tx_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // Framer FSM. The line value for the next bit is registered on the edge that enters that bit.
    always_ff @(posedge tx_sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_stop_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_bit <= 1'b0;
            r_line       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_line <= 1'b1;
                    if (w_load) begin
                        r_state      <= S_START;
                        r_shift      <= r_buf;
                        r_parity_bit <= w_parity_bit;
                        r_sample_cnt <= '0;
                        r_line       <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_sample_last) begin
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= S_DATA;
                        r_line       <= r_shift[0];
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SW'(1);
                    end
                end

                S_DATA: begin
                    if (w_sample_last) begin
                        r_sample_cnt <= '0;
                        r_shift      <= r_shift >> 1;
                        if (r_bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_line  <= r_parity_bit;
                            end else begin
                                r_state    <= S_STOP;
                                r_stop_cnt <= '0;
                                r_line     <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                            r_line    <= r_shift[1];
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SW'(1);
                    end
                end

                S_PARITY: begin
                    if (w_sample_last) begin
                        r_sample_cnt <= '0;
                        r_stop_cnt   <= '0;
                        r_state      <= S_STOP;
                        r_line       <= 1'b1;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SW'(1);
                    end
                end

                S_STOP: begin
                    if (w_stop_last) begin
                        r_done     <= 1'b1;
                        r_stop_cnt <= '0;
                        if (w_load) begin
                            r_state      <= S_START;
                            r_shift      <= r_buf;
                            r_parity_bit <= w_parity_bit;
                            r_sample_cnt <= '0;
                            r_line       <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_line  <= 1'b1;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + STW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit. Three instances (no parity, even, odd) share a clock and reset.
// Each frame is compared cycle by cycle against a bit list built from the framing rules.
module tb_uart_transmit;

    localparam int OS    = 16;
    localparam int STOPB = 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_transmit_if #(.DATA_BITS(8)) if0 ();
    uart_transmit_if #(.DATA_BITS(8)) if1 ();
    uart_transmit_if #(.DATA_BITS(8)) if2 ();

    uart_transmit #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(STOPB)) dut0 (
        .tx_sample_clk(clk), .reset_n(reset_n), .bus(if0));
    uart_transmit #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(STOPB)) dut1 (
        .tx_sample_clk(clk), .reset_n(reset_n), .bus(if1));
    uart_transmit #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(STOPB)) dut2 (
        .tx_sample_clk(clk), .reset_n(reset_n), .bus(if2));

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic w_line, w_busy, w_done, w_ready;

    always_comb begin
        w_line  = if0.serial_data_out;
        w_busy  = if0.tx_busy;
        w_done  = if0.tx_done;
        w_ready = if0.tx_ready;
        case (sel)
            1: begin
                w_line = if1.serial_data_out; w_busy = if1.tx_busy;
                w_done = if1.tx_done;         w_ready = if1.tx_ready;
            end
            2: begin
                w_line = if2.serial_data_out; w_busy = if2.tx_busy;
                w_done = if2.tx_done;         w_ready = if2.tx_ready;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_drive(input logic v, input logic [7:0] d);
        case (sel)
            1:       begin if1.tx_valid = v; if1.tx_data = d; end
            2:       begin if2.tx_valid = v; if2.tx_data = d; end
            default: begin if0.tx_valid = v; if0.tx_data = d; end
        endcase
    endtask

    // Offer one byte, hold valid until it is accepted, then drop it. Returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] d);
        bit ok = 0;
        @(negedge clk);
        set_drive(1'b1, d);
        for (int i = 0; i < 2000; i++) begin
            if (w_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        set_drive(1'b0, d);
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_start(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (w_line === 1'b0) begin ok = 1; break; end
        end
        chk("start_seen", {31'd0, ok}, 32'd1);
    endtask

    // Entered on the sample of frame cycle 0. Leaves on the sample one frame length later, which is where tx_done must be high.
    task automatic check_frame(input logic [7:0] b, input int mode, input string tag);
        logic exp_bits[$];
        logic [7:0] got = '0;
        logic got_par = 1'b0;
        logic exp_par;
        int bad_line = 0, bad_busy = 0, bad_done = 0, len;
        exp_par = logic'(($countones(b) % 2) != 0) ^ (mode == 2);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (mode != 0) exp_bits.push_back(exp_par);
        for (int i = 0; i < STOPB; i++) exp_bits.push_back(1'b1);
        len = exp_bits.size() * OS;
        for (int c = 0; c < len; c++) begin
            if (w_line !== exp_bits[c / OS]) bad_line++;
            if (w_busy !== 1'b1) bad_busy++;
            if (c > 0 && w_done !== 1'b0) bad_done++;
            if (c % OS == OS / 2) begin
                if (c / OS >= 1 && c / OS <= 8) got[c / OS - 1] = w_line;
                if (mode != 0 && c / OS == 9) got_par = w_line;
            end
            @(negedge clk);
        end
        chk({tag, "_line_cycles"}, bad_line, 0);
        chk({tag, "_busy_cycles"}, bad_busy, 0);
        chk({tag, "_early_done"}, bad_done, 0);
        chk({tag, "_decoded"}, {24'd0, got}, {24'd0, b});
        if (mode != 0) chk({tag, "_parity_bit"}, {31'd0, got_par}, {31'd0, exp_par});
        chk({tag, "_done_pulse"}, {31'd0, w_done}, 32'd1);
    endtask

    // One isolated frame: one-cycle start latency, full frame, busy drop, single-cycle tx_done.
    task automatic single(input logic [7:0] b, input int mode, input string tag);
        send(b);
        chk({tag, "_line_before_start"}, {31'd0, w_line}, 32'd1);
        @(negedge clk);
        chk({tag, "_start_low"}, {31'd0, w_line}, 32'd0);
        check_frame(b, mode, tag);
        chk({tag, "_busy_drop"}, {31'd0, w_busy}, 32'd0);
        chk({tag, "_line_idle"}, {31'd0, w_line}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, w_done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic [7:0] fb [3];
        int cnt;

        if0.tx_valid = 0; if0.tx_data = '0;
        if1.tx_valid = 0; if1.tx_data = '0;
        if2.tx_valid = 0; if2.tx_data = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line", {31'd0, w_line}, 32'd1);
        chk("rst_ready", {31'd0, w_ready}, 32'd1);
        chk("rst_busy", {31'd0, w_busy}, 32'd0);
        chk("rst_done", {31'd0, w_done}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        sel = 0;
        single(8'h33, 0, "b33");
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom);
            single(rb, 0, "rand");
        end

        // Back-to-back: second byte is taken during frame 1 and starts on frame 1's done edge.
        send(8'h30);
        @(negedge clk);
        chk("b2b_start", {31'd0, w_line}, 32'd0);
        fork
            begin
                check_frame(8'h30, 0, "b2b_f1");
                chk("b2b_no_gap_line", {31'd0, w_line}, 32'd0);
                check_frame(8'h37, 0, "b2b_f2");
                chk("b2b_end_busy", {31'd0, w_busy}, 32'd0);
            end
            send(8'h37);
        join
        repeat (2) @(negedge clk);

        sel = 1;
        single(8'h33, 1, "even33");
        single(8'($urandom), 1, "even_rand");
        sel = 2;
        single(8'h33, 2, "odd33");
        single(8'($urandom), 2, "odd_rand");

        // Flow control: valid stays high across three distinct bytes.
        sel = 0;
        fb[0] = 8'($urandom);
        do fb[1] = 8'($urandom); while (fb[1] == fb[0]);
        do fb[2] = 8'($urandom); while (fb[2] == fb[0] || fb[2] == fb[1]);
        fork
            begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    bit ok = 0;
                    set_drive(1'b1, fb[k]);
                    for (int i = 0; i < 1000; i++) begin
                        if (w_ready) begin ok = 1; break; end
                        @(negedge clk);
                    end
                    @(negedge clk);
                    chk("fc_accept", {31'd0, ok}, 32'd1);
                end
                set_drive(1'b0, 8'h00);
            end
            begin
                wait_start(200);
                for (int k = 0; k < 3; k++) check_frame(fb[k], 0, "fc");
            end
        join
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (w_line !== 1'b1 || w_busy !== 1'b0) cnt++;
            @(negedge clk);
        end
        chk("fc_no_extra_frame", cnt, 0);

        // Reset mid-frame: outputs go to reset values with no clock edge in between.
        send(8'($urandom));
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_line", {31'd0, w_line}, 32'd1);
        chk("mid_rst_ready", {31'd0, w_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, w_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, w_done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w_line !== 1'b1 || w_busy !== 1'b0 || w_ready !== 1'b1) cnt++;
        end
        chk("post_rst_idle", cnt, 0);

        // Abort in the 5th data bit of 0x55, then a clean 0x31 frame.
        send(8'h55);
        @(negedge clk);
        chk("abort_start", {31'd0, w_line}, 32'd0);
        repeat (5 * OS + 8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_line", {31'd0, w_line}, 32'd1);
        chk("abort_busy", {31'd0, w_busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_line !== 1'b1 || w_busy !== 1'b0) cnt++;
        end
        chk("abort_no_residue", cnt, 0);
        single(8'h31, 0, "resend31");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
